// File: rtl/fir_pkg.sv
// Constants and scaling helper shared by the 3-tap FIR stage and its decimating buffer.
package fir_pkg;

  localparam int unsigned FIR_IN_W  = 8;
  localparam int unsigned FIR_OUT_W = 16;
  localparam int unsigned SAMPLE_W  = 8;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef struct packed {
    logic                       sat;
    logic signed [SAMPLE_W-1:0] value;
  } scaled_t;

  // Round half toward +inf, arithmetic shift, then clip to the sample range.
  function automatic scaled_t round_sat(input logic signed [FIR_OUT_W-1:0] value,
                                        input int unsigned               shift);
    logic signed [FIR_OUT_W:0] ext;
    logic signed [FIR_OUT_W:0] r;
    scaled_t                   res;
    ext = {value[FIR_OUT_W-1], value};
    if (shift != 0) begin
      ext = ext + ((FIR_OUT_W+1)'(1) << (shift - 1));
    end
    r         = ext >>> shift;
    res.sat   = 1'b0;
    res.value = r[SAMPLE_W-1:0];
    if (r > (FIR_OUT_W+1)'(SAT_MAX)) begin
      res.sat   = 1'b1;
      res.value = SAT_MAX;
    end else if (r < (FIR_OUT_W+1)'(SAT_MIN)) begin
      res.sat   = 1'b1;
      res.value = SAT_MIN;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is always presented on rdata.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok_c, pop_ok_c;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO only lands if a pop frees the head slot the same cycle.
  always_comb begin
    pop_ok_c  = pop && !empty;
    push_ok_c = push && (!full || pop_ok_c);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok_c, pop_ok_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/fir_decim_buffer.sv
// Rescales FIR output to sample width with rounding/saturation, decimates,
// and buffers surviving samples in a FWFT FIFO drained over valid/ready.
module fir_decim_buffer
  import fir_pkg::*;
#(
  parameter int unsigned IN_W  = FIR_OUT_W,
  parameter int unsigned OUT_W = SAMPLE_W,
  parameter int unsigned SHIFT = 2,
  parameter int unsigned DECIM = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [IN_W-1:0]     in_sample,
  input  logic                       in_valid,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       sat,
  output logic                       overflow,
  input  logic                       clear_ovf
);

  localparam int unsigned CALC_W = IN_W + 1;
  localparam int unsigned PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0]          PH_LAST = PH_W'(DECIM - 1);
  localparam logic [CALC_W-1:0]        RND     = (SHIFT == 0) ? '0 :
                                                 (CALC_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0));
  localparam logic signed [CALC_W-1:0] LIM_HI  = CALC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [CALC_W-1:0] LIM_LO  = ~LIM_HI;

  logic [PH_W-1:0]          phase_q, phase_d;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [OUT_W-1:0]  s1_data_q, s1_data_d;
  logic                     sat_q, sat_d;
  logic                     overflow_q, overflow_d;

  logic                     keep_c;
  logic                     clip_c;
  logic                     pop_c;
  logic signed [CALC_W-1:0] rounded_c;
  logic signed [OUT_W-1:0]  scaled_c;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [OUT_W-1:0]         fifo_head;

  // Round half toward +inf in IN_W+1 bits, then clip to the output range.
  always_comb begin
    rounded_c = (signed'({in_sample[IN_W-1], in_sample}) + signed'(RND)) >>> SHIFT;
    clip_c    = 1'b0;
    scaled_c  = rounded_c[OUT_W-1:0];
    if (rounded_c > LIM_HI) begin
      clip_c   = 1'b1;
      scaled_c = LIM_HI[OUT_W-1:0];
    end else if (rounded_c < LIM_LO) begin
      clip_c   = 1'b1;
      scaled_c = LIM_LO[OUT_W-1:0];
    end
  end

  always_comb begin
    keep_c     = in_valid && (phase_q == '0);
    pop_c      = !fifo_empty && out_ready;
    phase_d    = phase_q;
    s1_valid_d = keep_c;
    s1_data_d  = s1_data_q;
    sat_d      = keep_c && clip_c;
    overflow_d = overflow_q;
    if (in_valid) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end
    if (keep_c) begin
      s1_data_d = scaled_c;
    end
    // Setting wins over a same-cycle clear so no drop goes unreported.
    if (s1_valid_q && fifo_full && !pop_c) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      sat_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      sat_q      <= sat_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid_q),
    .wdata (s1_data_q),
    .pop   (pop_c),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? signed'(fifo_head) : '0;
  assign sat       = sat_q;
  assign overflow  = overflow_q;

endmodule
